// File: rtl/issue_ctrl.sv
// Single-slot issue controller with scoreboard of busy destination registers.
// Tracks in-flight count, stalls on RAW/WAW, serializing ops and a full window.
module issue_ctrl #(
  parameter int MAX_INFLIGHT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_rs1_use,
  input  logic        in_rs2_use,
  input  logic        in_wen,
  input  logic        in_serial,
  output logic        in_ready,
  output logic        hold_en,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        rel_valid,
  input  logic [4:0]  rel_rd,
  input  logic        rel_wen,
  input  logic        flush,
  output logic [1:0]  state_o,
  output logic [3:0]  inflight_o,
  output logic [31:0] busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_READY  = 2'd1,
    ST_HAZARD = 2'd2,
    ST_SERIAL = 2'd3
  } st_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_INFLIGHT);

  st_t         r_state;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic        r_rs1_use;
  logic        r_rs2_use;
  logic        r_wen;
  logic        r_serial;
  logic [31:0] r_busy;
  logic [3:0]  r_inflight;
  logic        r_err;

  logic        w_issue;
  logic        w_rel_ok;
  logic        w_spur;
  logic [31:0] w_busy_nxt;
  logic [3:0]  w_inf_nxt;

  function automatic st_t f_class(
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic        u1,
    input logic        u2,
    input logic        wen,
    input logic        ser,
    input logic [31:0] busy,
    input logic [3:0]  inf
  );
    logic hz;
    hz = (u1 && rs1 != 5'd0 && busy[rs1]) ||
         (u2 && rs2 != 5'd0 && busy[rs2]) ||
         (wen && rd != 5'd0 && busy[rd]) ||
         (inf == LP_MAX);
    unique case (1'b1)
      (ser && inf != 4'd0): return ST_SERIAL;
      hz:                   return ST_HAZARD;
      default:              return ST_READY;
    endcase
  endfunction

  assign out_valid = (r_state == ST_READY) && !flush;
  assign w_issue   = out_valid && out_ready;
  assign in_ready  = reset && (r_state == ST_EMPTY || w_issue) && !flush;
  assign hold_en   = in_valid && in_ready;

  // A release with nothing outstanding is bogus and must not disturb state.
  assign w_rel_ok = rel_valid && (r_inflight != 4'd0);
  assign w_spur   = rel_valid && (r_inflight == 4'd0);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_rel_ok && rel_wen && rel_rd != 5'd0)
      w_busy_nxt[rel_rd] = 1'b0;
    if (w_issue && r_wen && r_rd != 5'd0)
      w_busy_nxt[r_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_inf_nxt = r_inflight;
    case ({w_issue, w_rel_ok})
      2'b10:   w_inf_nxt = r_inflight + 4'd1;
      2'b01:   w_inf_nxt = r_inflight - 4'd1;
      default: w_inf_nxt = r_inflight;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_use  <= 1'b0;
      r_rs2_use  <= 1'b0;
      r_wen      <= 1'b0;
      r_serial   <= 1'b0;
      r_busy     <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_inflight <= w_inf_nxt;
      if (w_spur)
        r_err <= 1'b1;
      if (hold_en) begin
        r_rs1     <= in_rs1;
        r_rs2     <= in_rs2;
        r_rd      <= in_rd;
        r_rs1_use <= in_rs1_use;
        r_rs2_use <= in_rs2_use;
        r_wen     <= in_wen;
        r_serial  <= in_serial;
        r_state   <= f_class(in_rs1, in_rs2, in_rd,
                             in_rs1_use, in_rs2_use,
                             in_wen, in_serial,
                             w_busy_nxt, w_inf_nxt);
      end else if (flush || w_issue || r_state == ST_EMPTY) begin
        r_rs1     <= '0;
        r_rs2     <= '0;
        r_rd      <= '0;
        r_rs1_use <= 1'b0;
        r_rs2_use <= 1'b0;
        r_wen     <= 1'b0;
        r_serial  <= 1'b0;
        r_state   <= ST_EMPTY;
      end else if (r_state != ST_READY) begin
        r_state <= f_class(r_rs1, r_rs2, r_rd,
                           r_rs1_use, r_rs2_use,
                           r_wen, r_serial,
                           w_busy_nxt, w_inf_nxt);
      end
    end
  end

  assign state_o    = r_state;
  assign inflight_o = r_inflight;
  assign busy_o     = r_busy;
  assign err_o      = r_err;

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 8: maximum issued-but-unreleased instructions (2..15).
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have in_valid  input  1  decode offers an instruction.
REQ-005 SHALL have in_rs1, in_rs2, in_rd  input  5 each  source/destination register indices.
REQ-006 SHALL have in_rs1_use, in_rs2_use, in_wen, in_serial  input  1 each  source reads, register write, serializing (fence/CSR).
REQ-007 SHALL have in_ready  output  1  slot accepts offer this cycle.
REQ-008 SHALL have hold_en  output  1  load enable for the decode pipeline register, equals in_valid & in_ready.
REQ-009 SHALL have out_valid  output  1  held instruction may issue to execute.
REQ-010 SHALL have out_ready  input  1  execute accepts; issue = out_valid & out_ready.
REQ-011 SHALL have rel_valid  input  1, rel_rd  input  5, rel_wen  input  1  one release per issued instruction (including killed ones; killed ones report rel_wen=0 or their rd).
REQ-012 SHALL have flush  input  1  discard held instruction.
REQ-013 SHALL have state_o  output  2, inflight_o  output  4, busy_o  output  32, err_o  output  1.

Function
REQ-014 SHALL hold one instruction slot (rs1, rs2, rd, use/wen/serial flags) plus registered state: EMPTY=0, READY=1, HAZARD=2, SERIAL=3.
REQ-015 SHALL drive out_valid = (state==READY) & !flush.
REQ-016 SHALL drive in_ready = (state==EMPTY | issue) & !flush.
REQ-017 SHALL keep busy[31:0]: on issue with wen & rd!=0 set busy[rd]; on rel_valid & rel_wen & rel_rd!=0 clear busy[rel_rd]; busy[0] always 0.
REQ-018 SHALL keep inflight: +1 on issue, -1 on rel_valid, unchanged when both; rel_valid at inflight 0 ignored and sets err_o (sticky until reset).
REQ-019 SHALL compute busy_next/inflight_next from this cycle's updates; next-state classification uses these next values.
REQ-020 SHALL classify the slot for next state, priority order: flush -> EMPTY; no slot held after the cycle -> EMPTY; serial & inflight_next!=0 -> SERIAL; hazard -> HAZARD; else READY.
REQ-021 SHALL define hazard = (rs1_use & rs1!=0 & busy_next[rs1]) | (rs2_use & rs2!=0 & busy_next[rs2]) | (wen & rd!=0 & busy_next[rd]) | inflight_next==MAX_INFLIGHT.
REQ-022 SHALL reclassify HAZARD/SERIAL every cycle; READY without issue stays READY (counts only fall, no new busy bits).
REQ-023 SHALL give release-to-issue latency of exactly 1 cycle: release in cycle N -> out_valid in N+1; no same-cycle bypass.
REQ-024 SHALL, on accept concurrent with issue, classify the new instruction against busy_next including the issuing instruction's rd.
REQ-025 SHALL on flush clear slot and state to EMPTY, ignore in_valid and suppress issue that cycle, leave busy and inflight untouched (releases still processed).
REQ-026 SHALL present inflight_o, busy_o, state_o directly from registers.

Reset
REQ-027 SHALL, while reset==0, asynchronously force state EMPTY, busy 0, inflight 0, err_o 0, slot fields 0; hence in_ready=1 only after deassert, out_valid=0, hold_en=0.
REQ-028 SHALL abandon any held instruction on reset mid-operation; no release expected afterwards.

Verification
REQ-029 SHALL cover RAW: issue x5 write, next instr reads x5 -> HAZARD until rel_rd=5 cycle N, out_valid at N+1.
REQ-030 SHALL cover x0: writer rd=0 then reader rs1=0 -> no busy bit, back-to-back issue, out_valid continuous.
REQ-031 SHALL cover serial: 3 in flight, in_serial=1 -> state SERIAL until third release at N, READY/out_valid at N+1.
REQ-032 SHALL cover cap: MAX_INFLIGHT=8, 8 independent issues, 9th -> HAZARD, one release -> issue next cycle, inflight_o back to 8.
REQ-033 SHALL cover flush with out_ready=1 and in_valid=1 same cycle -> no issue, no accept, state EMPTY, busy_o unchanged.
REQ-034 SHALL cover spurious release at inflight 0 -> err_o=1 and held; reset asserted mid-HAZARD -> all outputs to reset values immediately.
